// File: rtl/bip_debug_tx_pkg.sv
// -----------------------------------------------------------------------------
// bip_debug_tx_pkg
//   Shared definitions for the BIP debug report serializer: frame layout
//   constants and the serializer FSM state encoding.
// -----------------------------------------------------------------------------
package bip_debug_tx_pkg;

   localparam logic [7:0]  FRAME_HEADER = 8'hA5;
   localparam int unsigned FRAME_BYTES  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/bip_debug_tx.sv
// -----------------------------------------------------------------------------
// bip_debug_tx
//   Debug report serializer for the BIP processor. When the processor halts
//   (opcode returns to 0 after running) the final cycle count and accumulator
//   are snapshotted and sent as a 5-byte frame through an external UART TX:
//   A5, cnt[15:8], cnt[7:0], acc[15:8], acc[7:0]. One byte per handshake.
//
// Ports:
//   i_clock     system clock
//   i_reset     synchronous reset, active low
//   i_opcode    current decoded opcode, 0 = halt
//   i_cuenta    cycle count from the cycle counter
//   i_acc       accumulator value
//   i_tx_done   UART TX byte-finished pulse
//   o_tx_start  one-cycle pulse, UART TX loads o_tx_data
//   o_tx_data   byte to transmit
//   o_busy      frame in progress
//   o_done      one-cycle pulse, frame complete
// -----------------------------------------------------------------------------
module bip_debug_tx
   import bip_debug_tx_pkg::*;
#(
   parameter int unsigned CONTADOR_LENGTH = 11,
   parameter int unsigned DATA_LENGTH     = 16,
   parameter int unsigned OPCODE_LENGTH   = 5
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic [OPCODE_LENGTH-1:0]   i_opcode,
   input  logic [CONTADOR_LENGTH-1:0] i_cuenta,
   input  logic [DATA_LENGTH-1:0]     i_acc,
   input  logic                       i_tx_done,
   output logic                       o_tx_start,
   output logic [7:0]                 o_tx_data,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam logic [2:0] IDX_LAST = 3'(FRAME_BYTES - 1);

   state_t      state, state_next;
   logic        running;
   logic [2:0]  idx;
   logic [2:0]  sel_idx;
   logic [15:0] cnt_q;
   logic [15:0] acc_q;
   logic [7:0]  tx_data_q;
   logic [7:0]  byte_sel;
   logic        trigger;
   logic        advance;

   // State register
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the three status outputs depend on state only
   always_comb begin
      state_next = state;
      trigger    = 1'b0;
      advance    = 1'b0;
      o_tx_start = 1'b0;
      o_busy     = 1'b1;
      o_done     = 1'b0;
      case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (running && (i_opcode == '0)) begin
               trigger    = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            o_tx_start = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (i_tx_done) begin
               if (idx == IDX_LAST) begin
                  state_next = DONE;
               end else begin
                  advance    = 1'b1;
                  state_next = SEND;
               end
            end
         end
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The data register is loaded on the edge that enters SEND, so the byte is
   // already on o_tx_data during the o_tx_start cycle and held through WAIT.
   // The header needs no snapshot, so the trigger edge can load it directly.
   always_comb begin
      sel_idx = advance ? 3'(idx + 3'd1) : 3'd0;
      case (sel_idx)
         3'd0:    byte_sel = FRAME_HEADER;
         3'd1:    byte_sel = cnt_q[15:8];
         3'd2:    byte_sel = cnt_q[7:0];
         3'd3:    byte_sel = acc_q[15:8];
         3'd4:    byte_sel = acc_q[7:0];
         default: byte_sel = '0;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         running   <= 1'b0;
         idx       <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         tx_data_q <= '0;
      end else begin
         running <= (i_opcode != '0);
         if (trigger) begin
            idx       <= '0;
            cnt_q     <= 16'(i_cuenta);
            acc_q     <= 16'(i_acc);
            tx_data_q <= byte_sel;
         end else if (advance) begin
            idx       <= sel_idx;
            tx_data_q <= byte_sel;
         end
      end
   end

   assign o_tx_data = tx_data_q;

endmodule

// File: doc/bip_debug_tx.md
# bip_debug_tx

Debug report serializer for the BIP processor, sitting directly downstream of the cycle counter. When the program halts (opcode returns to 0), it snapshots the final cycle count and accumulator and sends them as a fixed 5-byte frame through the external UART transmitter, one byte per handshake. It re-arms only once the processor is running again.

## Interface

Parameters:
- CONTADOR_LENGTH, 11, width of the cycle-count input; must be ≤ 16
- DATA_LENGTH, 16, width of the accumulator input; must be ≤ 16
- OPCODE_LENGTH, 5, width of the opcode input

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  reset, synchronous, active-low
- i_opcode  in  OPCODE_LENGTH  current decoded opcode; 0 = halt
- i_cuenta  in  CONTADOR_LENGTH  cycle count from the cycle counter
- i_acc  in  DATA_LENGTH  accumulator value
- i_tx_done  in  1  one-cycle pulse from the UART TX: byte finished
- o_tx_start  out  1  one-cycle pulse: UART TX loads o_tx_data
- o_tx_data  out  8  byte to transmit
- o_busy  out  1  frame in progress (every state except IDLE)
- o_done  out  1  one-cycle pulse: frame complete

## Operation

- Register `running` is set to (i_opcode != 0) on every clock.
- Trigger condition: `running` = 1 and i_opcode = 0 while in IDLE. Sample this with the same edge that snapshots i_cuenta and i_acc into 16-bit registers, zero-extended.
- Frame, transmitted MSB first: 0xA5 header, cnt[15:8], cnt[7:0], acc[15:8], acc[7:0].
- FSM states:
  - IDLE: waits for the trigger. On trigger, clear the byte index to 0 and go to SEND.
  - SEND: o_tx_start = 1 for exactly one cycle. Load o_tx_data with byte[idx]. Go to WAIT.
  - WAIT: hold o_tx_data stable. On i_tx_done, if idx = 4 go to DONE; otherwise increment idx and go to SEND.
  - DONE: o_done = 1 for one cycle. Go to IDLE.
- i_tx_done is sampled only in WAIT. A pulse arriving in SEND, IDLE or DONE is ignored.
- A halt edge that occurs while not in IDLE is dropped; no frame is queued for it. `running` still tracks the opcode, so the block re-arms normally.
- Opcode staying 0 after the frame does not re-trigger. A new frame requires opcode ≠ 0 for at least one cycle, followed by 0.
- Snapshot registers are not updated while busy.

## Timing

- Reset (synchronous, i_reset = 0 at a rising edge): state = IDLE, idx = 0, `running` = 0, snapshots = 0, o_tx_start = 0, o_tx_data = 0x00, o_busy = 0, o_done = 0.
- Reset mid-frame aborts immediately. No further o_tx_start is issued.
- The first cycle after reset cannot trigger, because `running` is 0.
- Latency, trigger edge to o_tx_start: o_tx_start is high in the cycle immediately after the trigger edge.
- The next o_tx_start follows one cycle after i_tx_done is sampled in WAIT.
- o_done is high in the cycle after the 5th i_tx_done.
- Minimum frame length: 5 × (1 + UART byte time) + 1 cycles.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Structure

- Shared package holds:
  - FRAME_HEADER = 8'hA5
  - FRAME_BYTES = 5
  - state encoding: IDLE, SEND, WAIT, DONE (2 bits)
- Single module; no sub-module. The byte select is an in-module mux on idx.
- The UART TX is external and is instantiated at the top level alongside the cycle counter.

## Test plan

- Reset and idle: hold i_reset = 0 for 3 cycles with opcode = 3. Release and keep opcode = 0 throughout. Required: no o_tx_start, all outputs 0.
- Basic frame: run with opcode ≠ 0, then set opcode = 0 with i_cuenta = 11'd1234 and i_acc = 16'hBEEF. Answer each o_tx_start with i_tx_done 10 cycles later. Required bytes: A5, 04, D2, BE, EF, then o_done pulses once.
- Halt while busy: during WAIT of byte 2, pulse opcode to 2 for one cycle and back to 0. Required: frame completes unchanged, and no second frame follows.
- Re-arm: after DONE, set opcode = 1 for 4 cycles, then 0 with i_cuenta = 11'h7FF and i_acc = 0. Required: second frame A5, 07, FF, 00, 00.
- Spurious done: pulse i_tx_done in the SEND cycle and during IDLE. Required: the pulse is ignored, idx does not advance, and the byte is still sent once.
- Mid-frame reset: assert i_reset = 0 during WAIT of byte 3. Required: the next cycle shows IDLE, o_busy = 0, o_tx_data = 0. Then opcode 0 alone causes no trigger until opcode ≠ 0 has been seen.
